instrn_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the 32-bit MIPS core. Owns the program counter and drives the byte-addressed, combinational-read instruction memory. Each fetched word and its PC go into a 2-entry buffer that decode drains through a valid/ready handshake. Redirect (branch/jump) and halt requests arrive from the execute/control path.

---
 rtl/instrn_fetch_ctrl_if.sv | 24 ++
 rtl/instrn_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_instrn_fetch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/instrn_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction-memory port, redirect/halt control and decode handshake.
// The master side is the fetch controller; the slave side is memory plus decode/execute.
interface instrn_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_instrn;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        fault;

  modport master (
    output imem_addr, out_valid, out_instrn, out_pc, fault,
    input  imem_data, redirect_valid, redirect_pc, halt, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instrn, out_pc, fault,
    output imem_data, redirect_valid, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/instrn_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and fills a 2-entry {instrn, pc} buffer drained by decode.
// Optional macro IFETCH_ALIGN_CHECK_EN adds a sticky FAULT state on misaligned redirects.
module instrn_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic              clk,
  input logic              reset_n,
  instrn_fetch_ctrl_if.master bus
);

  typedef struct packed {
    logic [31:0] instrn;
    logic [31:0] pc;
  } entry_t;

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
`else
  typedef enum logic {RUN, HALTED} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  entry_t      ent_q [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        pop, fetch;

  assign pop   = (count != 2'd0) && bus.out_ready;
  // Redirect wins over everything: any pop or fetch in that cycle is dropped.
  assign fetch = (state == RUN) && !bus.redirect_valid && !bus.halt &&
                 ((count != 2'd2) || pop);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic bad_redirect;
  assign bad_redirect = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      RUN:     if (bus.halt)  state_nxt = HALTED;
      HALTED:  if (!bus.halt) state_nxt = RUN;
      default: state_nxt = state;
    endcase
`ifdef IFETCH_ALIGN_CHECK_EN
    if (bad_redirect) state_nxt = FAULT;
`endif
    // PC still loads a misaligned target so the bad address is visible on imem_addr.
    if (bus.redirect_valid) pc_nxt = bus.redirect_pc;
    else if (fetch)         pc_nxt = pc + PC_STEP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= pc_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (bus.redirect_valid) begin
      count  <= 2'd0;
      rd_ptr <= wr_ptr;
    end else begin
      if (fetch) begin
        ent_q[wr_ptr] <= '{instrn: bus.imem_data, pc: pc};
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({fetch, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // When empty the head pointer sits on a stale entry; its contents are don't-care.
  assign bus.imem_addr  = pc;
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_instrn = ent_q[rd_ptr].instrn;
  assign bus.out_pc     = ent_q[rd_ptr].pc;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign bus.fault = (state == FAULT);
`else
  assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_instrn_fetch_ctrl.sv
// Bench for instrn_fetch_ctrl: directed test-plan scenarios plus random traffic against a queue model.
module tb_instrn_fetch_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  instrn_fetch_ctrl_if ifc ();

  instrn_fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h2002_0005;
    if (a == 32'h4) return 32'h2003_000C;
    return (a * 32'h9E37_79B1) ^ 32'h00A5_5A00;
  endfunction

  assign ifc.imem_data = mem_f(ifc.imem_addr);

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_chk();
    chk("valid", {31'b0, ifc.out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_pc", ifc.out_pc, q[0].pc);
      chk("out_instrn", ifc.out_instrn, q[0].ins);
    end
    chk("imem_addr", ifc.imem_addr, m_pc);
    chk("fault", {31'b0, ifc.fault}, {31'b0, m_fault});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.halt           = 1'b0;
    ifc.out_ready      = 1'b0;
    #2;
    chk("rst_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("rst_instrn", ifc.out_instrn, 32'd0);
    chk("rst_pc", ifc.out_pc, 32'd0);
    chk("rst_fault", {31'b0, ifc.fault}, 32'd0);
    chk("rst_addr", ifc.imem_addr, 32'h0);
    q.delete();
    m_pc = 32'h0;
    m_halted = 1'b0;
    m_fault = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model by the spec rules, then compare after the edge.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit h);
    bit pop, fetch;
    ifc.out_ready      = rdy;
    ifc.redirect_valid = rv;
    ifc.redirect_pc    = rpc;
    ifc.halt           = h;
    pop = (q.size() != 0) && rdy;
    if (rv) begin
      q.delete();
      m_pc = rpc;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) m_fault = 1'b1;
`endif
    end else begin
      fetch = !m_halted && !m_fault && !h && (q.size() < 2 || pop);
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back('{ins: mem_f(m_pc), pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    if (!m_fault) m_halted = h;
    @(posedge clk);
    #1;
    model_chk();
  endtask

  initial begin
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.halt           = 1'b0;
    ifc.out_ready      = 1'b0;

    // Reset and stall
    do_reset();
    step(0, 0, 0, 0);
    chk("stall_v1", {31'b0, ifc.out_valid}, 32'd1);
    chk("stall_pc1", ifc.out_pc, 32'h0);
    chk("stall_ins1", ifc.out_instrn, 32'h2002_0005);
    step(0, 0, 0, 0);
    chk("stall_addr2", ifc.imem_addr, 32'h8);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("stall_hold", ifc.imem_addr, 32'h8);

    // Redirect with full buffer and simultaneous ready
    step(1, 1, 32'h10, 0);
    chk("redir_flush", {31'b0, ifc.out_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("redir_tgt", ifc.out_pc, 32'h10);

    // Streaming from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("stream_pc", ifc.out_pc, 32'(i * 4));
    end

    // Halt and resume
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("halt_empty", {31'b0, ifc.out_valid}, 32'd0);
    chk("halt_addr", ifc.imem_addr, 32'h8);
    step(1, 0, 0, 1);
    chk("halt_hold", ifc.imem_addr, 32'h8);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("resume_pc", ifc.out_pc, 32'h8);

    // Wrap-around
    step(1, 1, 32'hFFFF_FFF8, 0);
    step(1, 0, 0, 0);
    chk("wrap0", ifc.out_pc, 32'hFFFF_FFF8);
    step(1, 0, 0, 0);
    chk("wrap1", ifc.out_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("wrap2", ifc.out_pc, 32'h0000_0000);
    step(1, 0, 0, 0);
    chk("wrap3", ifc.out_pc, 32'h0000_0004);

    // Misaligned redirect
    step(0, 1, 32'h6, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'b0, ifc.fault}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      chk("mis_novalid", {31'b0, ifc.out_valid}, 32'd0);
      chk("mis_nofetch", ifc.imem_addr, 32'h6);
    end
    do_reset();
`else
    chk("mis_nofault", {31'b0, ifc.fault}, 32'd0);
    step(0, 0, 0, 0);
    chk("mis_pc", ifc.out_pc, 32'h6);
    chk("mis_ins", ifc.out_instrn, mem_f(32'h6));
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          rv, h;
      logic [31:0] rpc;
      if ($urandom_range(0, 299) == 0) do_reset();
      rv  = ($urandom_range(0, 19) == 0);
      rpc = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 31) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF0;
      h = ($urandom_range(0, 9) < 2);
      step(bit'($urandom_range(0, 1)), rv, rpc, h);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
